uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte requesters.
- Selects a requester, presents its byte to the UART TX with a one-cycle data_valid, and tracks the transmitter's busy flag through the frame.
- Supports a per-requester lock for multi-byte messages and flags a watchdog timeout if the transmitter never accepts.
- Sits between the host-side byte sources and the UART TX FSM/serializer/mux datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16, cycles to wait in WAIT_BUSY for tx_busy to rise before aborting.
- ID_W, $clog2(NUM_REQ), width of the granted-requester index.

Ports:
- clck  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester byte-ready request.
- lock  in  NUM_REQ  per-requester hold-grant for multi-byte message.
- req_data  in  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
- ack  out  NUM_REQ  one-cycle pulse: requester's byte consumed.
- grant  out  NUM_REQ  one-hot current owner, 0 when idle.
- grant_id  out  ID_W  index of current owner.
- tx_p_data  out  8  byte to UART TX p_data.
- tx_data_valid  out  1  to UART TX data_valid.
- tx_busy  in  1  from UART TX busy.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first; watchdog counter 0. Reset mid-operation drops tx_data_valid, grant and ack immediately, with no completion ack.
- All outputs are registered.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req and tx_busy==0, pick the winner: first set req bit searching from rr pointer+1 with wrap.
  - Latch req_data of the winner into tx_p_data; set grant and grant_id; go to LOAD.
  - If tx_busy==1 (link still busy), stay in IDLE.
- LOAD (exactly one cycle):
  - tx_data_valid=1 and ack[grant_id]=1.
  - Go to WAIT_BUSY and clear the watchdog.
  - Requester may change req_data or drop req from the next cycle; the transaction continues regardless.
- WAIT_BUSY:
  - tx_busy==1 -> WAIT_DONE.
  - Otherwise the counter increments. At count TIMEOUT-1: err_timeout=1 for one cycle, rr pointer=grant_id, grant cleared, go to IDLE.
- WAIT_DONE:
  - Hold grant while tx_busy==1.
  - On tx_busy==0, if lock[grant_id] && req[grant_id]: latch that requester's new byte, stay granted, go to LOAD. The rr pointer is unchanged.
  - Otherwise: rr pointer=grant_id, grant cleared, go to IDLE.
- Latency: req seen in IDLE at cycle t -> tx_data_valid at t+1 -> UART busy expected from t+2.
- ack, grant and tx_data_valid are never asserted in the same cycle as err_timeout.
- lock without req is ignored. lock on a non-granted requester has no effect on arbitration.
- Back-to-back locked bytes incur a one-cycle gap after busy falls (WAIT_DONE->LOAD).
- tx_p_data holds its value until the next load; it is 0 only after reset.

Decomposition:
- Package uart_tx_pkg holds:
  - state encoding localparams (IDLE=2'b00, LOAD=2'b01, WAIT_BUSY=2'b10, WAIT_DONE=2'b11);
  - the default TIMEOUT;
  - the byte width constant 8.
- One combinational sub-module, uart_rr_arbiter:
  - inputs: req vector and rr pointer;
  - outputs: one-hot winner, winner index and any-valid.

Test Plan:
- Single byte:
  - Stimulus: req=0001, req_data[7:0]=8'hA5, tx_busy model rises 1 cycle after valid and falls 11 cycles later.
  - Response: tx_data_valid pulses once with tx_p_data=8'hA5; ack=0001 in the same cycle; grant=0001 until busy falls, then 0.
- Fairness:
  - Stimulus: req=1111 held, lock=0.
  - Response: grant_id sequence 0,1,2,3,0; one ack per requester per round.
- Lock:
  - Stimulus: req=0101, lock=0100 held for 3 bytes (8'h11, 8'h22, 8'h33).
  - Response: requester 2 sends 11,22,33 consecutively; then lock drops and requester 0 is granted next.
- Watchdog:
  - Stimulus: req=0010, tx_busy stuck 0.
  - Response: ack=0010 in LOAD; err_timeout pulses 16 cycles after LOAD; state IDLE; requester 1 is not re-acked for that byte; next winner with req=0011 is 0.
- Busy in IDLE:
  - Stimulus: req=0001 while tx_busy=1 externally.
  - Response: no tx_data_valid until the cycle after tx_busy falls.
- Reset mid-frame:
  - Stimulus: rst=1 asynchronously in WAIT_DONE.
  - Response: grant, ack, tx_data_valid, tx_p_data and err_timeout go to 0 without waiting for a clock edge; after release with req=1000|0001, requester 0 wins.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and constants for the UART TX scheduler
package uart_tx_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD      = 2'b01,
    WAIT_BUSY = 2'b10,
    WAIT_DONE = 2'b11
  } state_t;
  localparam int TIMEOUT_DEF = 16;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: picks the first set request after ptr, wrapping around
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [ID_W-1:0]    win_id,
  output logic               any
);
  logic [ID_W-1:0] j;
  // Scan farthest-first so the nearest request after ptr is the one left standing
  always_comb begin
    win_id = '0;
    j = '0;
    for (int k = NUM_REQ; k > 0; k--) begin
      j = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) win_id = j;
    end
  end
  assign any = |req;
  assign win = any ? NUM_REQ'(1) << win_id : '0;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART TX among NUM_REQ byte sources,
// with per-requester lock for multi-byte messages and a watchdog on tx_busy.
module uart_tx_sched
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clck,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ID_W-1:0]           grant_id,
  output logic [BYTE_W-1:0]         tx_p_data,
  output logic                      tx_data_valid,
  input  logic                      tx_busy,
  output logic                      err_timeout
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [ID_W-1:0] rr, rr_n, grant_id_n, win_id;
  logic [NUM_REQ-1:0] win, ack_n, grant_n;
  logic [WD_W-1:0] wd, wd_n;
  logic [BYTE_W-1:0] p_data_n, win_data, own_data;
  logic any, valid_n, err_n, keep;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req), .ptr(rr), .win(win), .win_id(win_id), .any(any)
  );

  assign win_data = req_data[int'(win_id)*BYTE_W +: BYTE_W];
  assign own_data = req_data[int'(grant_id)*BYTE_W +: BYTE_W];
  assign keep = lock[grant_id] & req[grant_id];

  // Every output is computed one cycle ahead so the ports come straight from flops
  always_comb begin
    state_n = state;
    rr_n = rr;
    wd_n = wd;
    grant_n = grant;
    grant_id_n = grant_id;
    p_data_n = tx_p_data;
    valid_n = 1'b0;
    ack_n = '0;
    err_n = 1'b0;
    case (state)
      IDLE: if (any && !tx_busy) begin
        state_n = LOAD;
        grant_n = win;
        grant_id_n = win_id;
        p_data_n = win_data;
        valid_n = 1'b1;
        ack_n = win;
      end
      LOAD: begin
        state_n = WAIT_BUSY;
        wd_n = '0;
      end
      WAIT_BUSY: if (tx_busy) state_n = WAIT_DONE;
        else if (wd == WD_W'(TIMEOUT - 1)) begin
          err_n = 1'b1;
          rr_n = grant_id;
          grant_n = '0;
          state_n = IDLE;
        end else wd_n = wd + 1'b1;
      WAIT_DONE: if (!tx_busy) begin
        if (keep) begin
          state_n = LOAD;
          p_data_n = own_data;
          valid_n = 1'b1;
          ack_n = grant;
        end else begin
          rr_n = grant_id;
          grant_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr <= ID_W'(NUM_REQ - 1);
      wd <= '0;
      grant <= '0;
      grant_id <= '0;
      tx_p_data <= '0;
      tx_data_valid <= 1'b0;
      ack <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      rr <= rr_n;
      wd <= wd_n;
      grant <= grant_n;
      grant_id <= grant_id_n;
      tx_p_data <= p_data_n;
      tx_data_valid <= valid_n;
      ack <= ack_n;
      err_timeout <= err_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: checks the scheduler every cycle against an event-level model of its
// rules, plus an arbitration vector table and directed multi-cycle sequences.
module tb_uart_tx_sched;
  localparam int N = 4;
  localparam int IW = 2;
  localparam int TO = 16;

  logic clck = 1'b0, rst = 1'b1, tx_busy = 1'b0;
  logic [N-1:0] req = '0, lock = '0, ack, grant;
  logic [31:0] req_data = '0;
  logic [IW-1:0] grant_id;
  logic [7:0] tx_p_data;
  logic tx_data_valid, err_timeout;

  uart_tx_sched #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clck(clck), .rst(rst), .req(req), .lock(lock), .req_data(req_data),
    .ack(ack), .grant(grant), .grant_id(grant_id), .tx_p_data(tx_p_data),
    .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .err_timeout(err_timeout)
  );

  always #5 clck = ~clck;

  int tests = 0, fails = 0, cyc = 0;
  logic drv_rst = 1'b1;
  logic [N-1:0] drv_req = '0, drv_lock = '0;
  logic [31:0] drv_data = '0;
  int uart_len = 11, bcnt = 0;
  bit pend = 0, uart_stall = 0, rand_stall = 0, ext_busy = 0;

  bit m_act, m_seen;
  int m_own, m_rr, m_load, m_idle_from;
  logic [7:0] m_pd;
  bit e_valid, e_err;
  logic [N-1:0] e_ack, e_grant;
  logic [7:0] e_pd;
  int e_id;

  int v_at, g_id, nv, g_at, e_at, na, d_at, v_prev;
  logic [7:0] g_pd;
  logic [N-1:0] g_ack;

  typedef struct {
    logic [N-1:0] r;
    int id;
    logic [7:0] pd;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic mreset();
    m_act = 0; m_seen = 0; m_own = 0; m_rr = N - 1; m_load = 0; m_idle_from = 0; m_pd = '0;
    e_valid = 0; e_err = 0; e_ack = '0; e_grant = '0; e_pd = '0; e_id = 0;
    bcnt = 0; pend = 0;
  endtask

  // Predicts next-cycle outputs from the rules: who owns the link, when busy rose/fell,
  // whether a locked owner keeps the link, and the round-robin pick when idle.
  task automatic model_step();
    int w;
    e_valid = 0;
    e_err = 0;
    if (drv_rst) begin
      mreset();
      return;
    end
    if (m_act) begin
      if (cyc > m_load) begin
        if (!m_seen && tx_busy) m_seen = 1;
        else if (!m_seen && cyc == m_load + TO) begin
          e_err = 1; m_act = 0; m_rr = m_own; m_idle_from = cyc + 1;
        end else if (m_seen && !tx_busy) begin
          if (drv_lock[IW'(m_own)] && drv_req[IW'(m_own)]) begin
            e_valid = 1; m_load = cyc + 1; m_seen = 0; m_pd = drv_data[m_own*8 +: 8];
          end else begin
            m_act = 0; m_rr = m_own; m_idle_from = cyc + 1;
          end
        end
      end
    end else if (cyc >= m_idle_from && drv_req != 0 && !tx_busy) begin
      w = m_rr;
      do w = (w + 1) % N; while (!drv_req[IW'(w)]);
      e_valid = 1; m_act = 1; m_own = w; m_load = cyc + 1; m_seen = 0;
      m_pd = drv_data[w*8 +: 8];
    end
    e_ack = e_valid ? N'(1) << m_own : '0;
    e_grant = m_act ? N'(1) << m_own : '0;
    e_id = m_own;
    e_pd = m_pd;
  endtask

  task automatic tick();
    @(posedge clck);
    #1;
    cyc++;
    chk("valid", tx_data_valid, e_valid);
    chk("ack", ack, e_ack);
    chk("grant", grant, e_grant);
    chk("p_data", tx_p_data, e_pd);
    chk("err_timeout", err_timeout, e_err);
    if (e_grant != 0) chk("grant_id", grant_id, e_id);
    if (bcnt > 0) bcnt--;
    if (pend) begin
      bcnt = uart_len;
      pend = 0;
    end
    if (tx_data_valid && !uart_stall && !(rand_stall && $urandom_range(0, 7) == 0)) pend = 1;
    tx_busy = ext_busy || bcnt > 0;
    rst = drv_rst; req = drv_req; lock = drv_lock; req_data = drv_data;
    model_step();
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (tx_data_valid) begin
        v_at = cyc; g_id = grant_id; g_pd = tx_p_data; g_ack = ack;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL wait_valid: no tx_data_valid within %0d cycles, required one", max);
  endtask

  task automatic wait_idle(input int max);
    nv = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (grant == 0) begin
        g_at = cyc;
        return;
      end
      if (tx_data_valid) nv++;
    end
    tests++;
    fails++;
    $display("FAIL wait_idle: grant still 'h%0h after %0d cycles, required 0", grant, max);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: run did not finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl[0]  = '{4'b1111, 0, 8'hA0};
    tbl[1]  = '{4'b1111, 1, 8'hB1};
    tbl[2]  = '{4'b1111, 2, 8'hC2};
    tbl[3]  = '{4'b1111, 3, 8'hD3};
    tbl[4]  = '{4'b1111, 0, 8'hA0};
    tbl[5]  = '{4'b1001, 3, 8'hD3};
    tbl[6]  = '{4'b1001, 0, 8'hA0};
    tbl[7]  = '{4'b0100, 2, 8'hC2};
    tbl[8]  = '{4'b0011, 0, 8'hA0};
    tbl[9]  = '{4'b0011, 1, 8'hB1};
    tbl[10] = '{4'b1010, 3, 8'hD3};
    tbl[11] = '{4'b1010, 1, 8'hB1};
    mreset();
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_valid", tx_data_valid, 0);
    chk("rst_p_data", tx_p_data, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err_timeout, 0);

    drv_rst = 0; drv_req = 4'b0001; drv_data = 32'h000000A5;
    wait_valid(5);
    chk("single_id", g_id, 0);
    chk("single_data", g_pd, 8'hA5);
    chk("single_ack", g_ack, 4'b0001);
    drv_req = '0;
    wait_idle(40);
    chk("single_release_cycle", g_at - v_at, 13);
    chk("single_extra_valid", nv, 0);

    drv_rst = 1; tick(); tick(); drv_rst = 0;
    drv_data = 32'hD3C2B1A0;
    for (int i = 0; i < 12; i++) begin
      drv_req = tbl[i].r;
      wait_valid(40);
      chk($sformatf("tbl%0d_id", i), g_id, tbl[i].id);
      chk($sformatf("tbl%0d_data", i), g_pd, tbl[i].pd);
      drv_req = '0;
      wait_idle(40);
    end

    drv_req = 4'b0101; drv_lock = 4'b0100; drv_data = 32'hD311B1A0;
    wait_valid(40);
    chk("lock1_id", g_id, 2); chk("lock1_data", g_pd, 8'h11);
    v_prev = v_at; drv_data[23:16] = 8'h22;
    wait_valid(40);
    chk("lock2_id", g_id, 2); chk("lock2_data", g_pd, 8'h22); chk("lock2_gap", v_at - v_prev, 13);
    v_prev = v_at; drv_data[23:16] = 8'h33;
    wait_valid(40);
    chk("lock3_id", g_id, 2); chk("lock3_data", g_pd, 8'h33); chk("lock3_gap", v_at - v_prev, 13);
    v_prev = v_at; drv_lock = '0;
    wait_valid(40);
    chk("unlock_id", g_id, 0); chk("unlock_data", g_pd, 8'hA0); chk("unlock_gap", v_at - v_prev, 14);
    drv_req = '0;
    wait_idle(40);

    drv_req = 4'b0010; uart_stall = 1;
    wait_valid(40);
    chk("wd_id", g_id, 1); chk("wd_ack", g_ack, 4'b0010);
    drv_req = '0; e_at = 0; na = 0;
    for (int i = 0; i < 40 && e_at == 0; i++) begin
      tick();
      if (ack != 0) na++;
      if (err_timeout) e_at = cyc;
    end
    chk("wd_err_cycle", e_at - v_at, 17);
    chk("wd_no_reack", na, 0);
    drv_req = 4'b0011; uart_stall = 0;
    wait_valid(10);
    chk("wd_next_id", g_id, 0); chk("wd_next_gap", v_at - e_at, 2);
    drv_req = '0;
    wait_idle(40);

    ext_busy = 1; drv_req = 4'b0001; nv = 0;
    repeat (6) begin
      tick();
      if (tx_data_valid) nv++;
    end
    chk("busy_idle_no_valid", nv, 0);
    ext_busy = 0;
    tick();
    d_at = cyc;
    wait_valid(10);
    chk("busy_idle_gap", v_at - d_at, 1); chk("busy_idle_id", g_id, 0);
    drv_req = '0;
    wait_idle(40);

    drv_req = 4'b1001; drv_data = 32'hD3C2B1A0;
    wait_valid(40);
    chk("mid_id", g_id, 3); chk("mid_data", g_pd, 8'hD3);
    repeat (5) tick();
    chk("pre_rst_grant", grant, 4'b1000);
    #3;
    rst = 1; drv_rst = 1;
    #1;
    chk("async_grant", grant, 0);
    chk("async_ack", ack, 0);
    chk("async_valid", tx_data_valid, 0);
    chk("async_p_data", tx_p_data, 0);
    chk("async_err", err_timeout, 0);
    mreset();
    tick();
    drv_rst = 0;
    wait_valid(5);
    chk("post_rst_id", g_id, 0); chk("post_rst_data", g_pd, 8'hA0);
    drv_req = '0;
    wait_idle(40);

    rand_stall = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) drv_req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) drv_lock = N'($urandom_range(0, 15));
      drv_data = $urandom;
      uart_len = $urandom_range(1, 6);
      ext_busy = $urandom_range(0, 19) == 0;
      tick();
    end
    rand_stall = 0; ext_busy = 0; drv_req = '0; drv_lock = '0;
    wait_idle(80);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
